fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_addr_gen.sv | 33 +++
 rtl/fir_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencing controller: state encoding,
// default tap count and BRAM word stride.
package fir_pkg;

  // Default number of filter taps.
  localparam int TAPE_NUM_DEF = 11;

  // BRAM byte-address stride between consecutive 32-bit words.
  localparam int WORD_STRIDE = 4;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    WAIT_IN = 3'd2,
    CALC    = 3'd3,
    OUT     = 3'd4,
    DONE    = 3'd5
  } fir_state_e;

  // Index width able to hold values 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_addr_gen.sv
// Circular data-BRAM address generator: returns the byte address of the
// sample k steps older than the newest one at wptr, wrapping modulo Tape_Num.
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int Tape_Num    = TAPE_NUM_DEF,
  parameter int IW          = idx_width(Tape_Num),
  parameter int KW          = idx_width(Tape_Num + 1)
) (
  input  logic [IW-1:0]          wptr,
  input  logic [KW-1:0]          k,
  output logic [pADDR_WIDTH-1:0] addr
);

  // One extra bit so wptr + Tape_Num - k never overflows.
  logic [KW:0] w_s;
  logic [KW:0] k_s;
  logic [KW:0] idx_s;

  // Modulo subtraction (wptr - k) mod Tape_Num, then scale to a byte address.
  always_comb begin
    w_s = (KW + 1)'(wptr);
    k_s = (KW + 1)'(k);
    if (w_s >= k_s) begin
      idx_s = w_s - k_s;
    end else begin
      idx_s = w_s + (KW + 1)'(Tape_Num) - k_s;
    end
    addr = pADDR_WIDTH'(idx_s) * pADDR_WIDTH'(WORD_STRIDE);
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencing controller: clears the sample BRAM, accepts one input sample
// at a time, steps the tap/data BRAM addresses for a full convolution, drives
// the external MAC and presents each result on the output stream.
// Optional feature: define FIR_SEQ_TLAST_CHECK_EN to flag ss_tlast mismatches
// on the sticky err output; otherwise err is tied low and ss_tlast is ignored.
// acc_in is expected to present the running sum including the term enabled
// by mac_en in the same cycle, so it is captured when CALC ends.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = TAPE_NUM_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_len,
  input  logic                   ap_done_clr,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   err,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic                   mac_clr,
  output logic                   mac_en,
  input  logic [pDATA_WIDTH-1:0] acc_in
);

  localparam int IW = idx_width(Tape_Num);
  localparam int KW = idx_width(Tape_Num + 1);
  localparam logic [KW-1:0] K_LAST_INIT = KW'(Tape_Num - 1);
  localparam logic [KW-1:0] K_LAST_CALC = KW'(Tape_Num);
  localparam logic [IW-1:0] W_LAST      = IW'(Tape_Num - 1);

  fir_state_e             state_r;
  fir_state_e             state_s;
  logic [KW-1:0]          k_r;
  logic [IW-1:0]          wptr_r;
  logic [31:0]            count_r;
  logic [31:0]            len_r;
  logic [pDATA_WIDTH-1:0] sm_tdata_r;
  logic                   sm_tlast_r;
  logic                   ap_done_r;

  logic                   start_acc_s;
  logic                   hs_in_s;
  logic                   hs_out_s;
  logic                   last_s;
  logic                   done_set_s;
  logic [pADDR_WIDTH-1:0] calc_addr_s;

  assign start_acc_s = (state_r == IDLE) && cfg_start;
  assign hs_in_s     = (state_r == WAIT_IN) && ss_tvalid;
  assign hs_out_s    = (state_r == OUT) && sm_tready;
  assign last_s      = (count_r == (len_r - 32'd1));
  assign done_set_s  = (state_s == DONE) && (state_r != DONE);

  fir_addr_gen #(
    .pADDR_WIDTH (pADDR_WIDTH),
    .Tape_Num    (Tape_Num),
    .IW          (IW),
    .KW          (KW)
  ) u_addr_gen (
    .wptr (wptr_r),
    .k    (k_r),
    .addr (calc_addr_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-state BRAM / MAC / stream controls.
  always_comb begin
    state_s   = state_r;
    ap_idle   = 1'b0;
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    data_WE   = 4'h0;
    data_A    = '0;
    data_Di   = '0;
    tap_A     = '0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    case (state_r)
      IDLE: begin
        ap_idle = 1'b1;
        if (cfg_start) begin
          state_s = INIT;
        end else begin
          state_s = IDLE;
        end
      end
      INIT: begin
        data_WE = 4'hF;
        data_A  = pADDR_WIDTH'(k_r) * pADDR_WIDTH'(WORD_STRIDE);
        if (k_r == K_LAST_INIT) begin
          if (len_r == 32'd0) begin
            state_s = DONE;
          end else begin
            state_s = WAIT_IN;
          end
        end else begin
          state_s = INIT;
        end
      end
      WAIT_IN: begin
        ss_tready = 1'b1;
        data_A    = pADDR_WIDTH'(wptr_r) * pADDR_WIDTH'(WORD_STRIDE);
        data_Di   = ss_tdata;
        if (ss_tvalid) begin
          data_WE = 4'hF;
          mac_clr = 1'b1;
          state_s = CALC;
        end else begin
          state_s = WAIT_IN;
        end
      end
      CALC: begin
        // Read data arrives one cycle after the address, so MAC trails by one.
        mac_en = (k_r != '0);
        if (k_r < K_LAST_CALC) begin
          tap_A  = pADDR_WIDTH'(k_r) * pADDR_WIDTH'(WORD_STRIDE);
          data_A = calc_addr_s;
        end else begin
          tap_A  = '0;
          data_A = '0;
        end
        if (k_r == K_LAST_CALC) begin
          state_s = OUT;
        end else begin
          state_s = CALC;
        end
      end
      OUT: begin
        sm_tvalid = 1'b1;
        if (sm_tready) begin
          if (last_s) begin
            state_s = DONE;
          end else begin
            state_s = WAIT_IN;
          end
        end else begin
          state_s = OUT;
        end
      end
      DONE: begin
        ap_idle = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Step counter shared by INIT (word index) and CALC (tap index).
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r <= '0;
    end else begin
      case (state_r)
        INIT:    k_r <= (k_r == K_LAST_INIT) ? '0 : k_r + KW'(1);
        CALC:    k_r <= (k_r == K_LAST_CALC) ? '0 : k_r + KW'(1);
        default: k_r <= '0;
      endcase
    end
  end

  // Run bookkeeping: circular write pointer, sample count and latched length.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= '0;
      count_r <= 32'd0;
      len_r   <= 32'd0;
    end else if (start_acc_s) begin
      wptr_r  <= '0;
      count_r <= 32'd0;
      len_r   <= cfg_len;
    end else if (hs_out_s) begin
      wptr_r  <= (wptr_r == W_LAST) ? '0 : wptr_r + IW'(1);
      count_r <= count_r + 32'd1;
    end else begin
      wptr_r  <= wptr_r;
      count_r <= count_r;
      len_r   <= len_r;
    end
  end

  // Output capture: result and last flag latched as CALC hands over to OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      sm_tdata_r <= '0;
      sm_tlast_r <= 1'b0;
    end else if ((state_r == CALC) && (k_r == K_LAST_CALC)) begin
      sm_tdata_r <= acc_in;
      sm_tlast_r <= last_s;
    end else if (hs_out_s) begin
      sm_tdata_r <= sm_tdata_r;
      sm_tlast_r <= 1'b0;
    end else begin
      sm_tdata_r <= sm_tdata_r;
      sm_tlast_r <= sm_tlast_r;
    end
  end

  // Sticky completion flag; a new completion beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ap_done_r <= 1'b0;
    end else if (done_set_s) begin
      ap_done_r <= 1'b1;
    end else if (ap_done_clr || start_acc_s) begin
      ap_done_r <= 1'b0;
    end else begin
      ap_done_r <= ap_done_r;
    end
  end

  assign sm_tdata = sm_tdata_r;
  assign sm_tlast = sm_tlast_r;
  assign ap_done  = ap_done_r;

`ifdef FIR_SEQ_TLAST_CHECK_EN
  logic err_r;

  // Sticky flag: input tlast disagrees with the expected final sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (start_acc_s) begin
      err_r <= 1'b0;
    end else if (hs_in_s && (ss_tlast != last_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  logic tlast_unused_s;
  logic hs_in_unused_s;

  assign tlast_unused_s = ss_tlast;
  assign hs_in_unused_s = hs_in_s;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: BRAM and accumulator environment,
// randomized streams compared against a direct convolution model.
module tb_fir_seq_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;
`ifdef FIR_SEQ_TLAST_CHECK_EN
  localparam bit TLAST_CHK = 1'b1;
`else
  localparam bit TLAST_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [31:0]   cfg_len;
  logic          ap_done_clr;
  logic          ap_idle, ap_done, err;
  logic          ss_tvalid, ss_tlast, ss_tready;
  logic [DW-1:0] ss_tdata;
  logic          sm_tvalid, sm_tlast, sm_tready;
  logic [DW-1:0] sm_tdata;
  logic [AW-1:0] tap_A, data_A;
  logic [3:0]    data_WE;
  logic [DW-1:0] data_Di;
  logic          mac_clr, mac_en;
  logic [DW-1:0] acc_in;

  always #5 clk = ~clk;

  fir_seq_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .ap_done_clr(ap_done_clr), .ap_idle(ap_idle), .ap_done(ap_done), .err(err),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .tap_A(tap_A), .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di),
    .mac_clr(mac_clr), .mac_en(mac_en), .acc_in(acc_in)
  );

  // Environment: tap/data BRAMs with one-cycle read latency, external MAC.
  logic [31:0] tap_mem  [0:1023];
  logic [31:0] data_mem [0:1023];
  logic [31:0] tap_do, data_do, acc_r;

  always @(posedge clk) begin
    tap_do <= tap_mem[tap_A >> 2];
    if (data_WE == 4'hF) data_mem[data_A >> 2] <= data_Di;
    data_do <= data_mem[data_A >> 2];
  end

  assign acc_in = mac_en ? acc_r + tap_do * data_do : acc_r;

  always @(posedge clk) begin
    if (rst || mac_clr) acc_r <= 32'd0;
    else                acc_r <= acc_in;
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] h [NT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: y[n] = sum_k h[k] * x[n-k], history before the run is zero.
  function automatic logic [31:0] ref_y(input logic [31:0] xs[$], input int n);
    logic [31:0] s = 32'd0;
    for (int k = 0; k < NT; k++) begin
      if (n - k >= 0) s = s + h[k] * xs[n - k];
    end
    return s;
  endfunction

  task automatic load_taps(input bit random_taps);
    for (int i = 0; i < NT; i++) begin
      h[i] = random_taps ? $urandom : 32'(i + 1);
      tap_mem[i] = h[i];
    end
  endtask

  task automatic pulse_start(input logic [31:0] len);
    @(negedge clk);
    cfg_len   = len;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // mode: 0 = always ready, 1 = random gaps/backpressure, 2 = first output stalled 7 cycles.
  task automatic run_stream(input logic [31:0] xs[$], input int tlast_at, input int mode,
                            input bit poke, input logic exp_err);
    int len = xs.size();
    logic [31:0] ys[$];
    int in_idx = 0, out_idx = 0, cyc = 0, acc_cyc = 0, stall_cnt = 0;
    bit in_out = 1'b0;
    int budget = 60 * len + 100;
    for (int n = 0; n < len; n++) ys.push_back(ref_y(xs, n));
    pulse_start(32'(len));
    while (!(out_idx == len && ap_done) && cyc < budget) begin
      ss_tvalid = (in_idx < len) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      ss_tdata  = (in_idx < len) ? xs[in_idx] : 32'd0;
      ss_tlast  = (tlast_at >= 0) ? (in_idx == tlast_at) : (in_idx == len - 1);
      if (mode == 1)                        sm_tready = ($urandom_range(0, 2) != 0);
      else if (mode == 2 && out_idx == 0)   sm_tready = (stall_cnt >= 7);
      else                                  sm_tready = 1'b1;
      cfg_start = poke && (cyc == 20);
      #1;
      if (ss_tready && ss_tvalid) begin
        in_idx++;
        acc_cyc = cyc;
      end
      if (sm_tvalid) begin
        chk("in_ready_during_out", 32'(ss_tready), 32'd0);
        if (out_idx >= len) begin
          chk("extra_output", 32'd1, 32'd0);
        end else begin
          if (!in_out) begin
            chk("latency", 32'(cyc - acc_cyc), 32'(NT + 2));
            in_out = 1'b1;
          end
          chk("sm_tdata", sm_tdata, ys[out_idx]);
          chk("sm_tlast", 32'(sm_tlast), 32'(out_idx == len - 1));
        end
        if (sm_tready) begin
          out_idx++;
          in_out    = 1'b0;
          stall_cnt = 0;
        end else begin
          stall_cnt++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0;
    ss_tvalid = 1'b0;
    chk("outputs_seen", 32'(out_idx), 32'(len));
    chk("ap_done_set", 32'(ap_done), 32'd1);
    chk("ap_idle_done", 32'(ap_idle), 32'd1);
    chk("err", 32'(err), 32'(exp_err));
    @(negedge clk);
    chk("ap_done_sticky", 32'(ap_done), 32'd1);
    chk("idle_after", 32'(ap_idle), 32'd1);
    chk("err_sticky", 32'(err), 32'(exp_err));
    ap_done_clr = 1'b1;
    @(negedge clk);
    ap_done_clr = 1'b0;
    #1;
    chk("ap_done_clr", 32'(ap_done), 32'd0);
  endtask

  initial begin
    logic [31:0] xs[$];
    int n, b;
    bit seen;
    rst = 1'b1; cfg_start = 1'b0; cfg_len = 32'd0; ap_done_clr = 1'b0;
    ss_tvalid = 1'b0; ss_tdata = 32'd0; ss_tlast = 1'b0; sm_tready = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      tap_mem[i]  = $urandom;
      data_mem[i] = $urandom;
    end
    load_taps(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_ap_idle", 32'(ap_idle), 32'd1);
    chk("rst_ap_done", 32'(ap_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ss_tready", 32'(ss_tready), 32'd0);
    chk("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    chk("rst_sm_tlast", 32'(sm_tlast), 32'd0);
    chk("rst_sm_tdata", sm_tdata, 32'd0);
    chk("rst_mac", {30'd0, mac_en, mac_clr}, 32'd0);
    chk("rst_data_WE", 32'(data_WE), 32'd0);
    chk("rst_addr", {8'd0, tap_A, data_A}, 32'd0);
    chk("rst_data_Di", data_Di, 32'd0);
    rst = 1'b0;

    // Small known sequence: expected 1, 4, 10.
    xs = {32'd1, 32'd2, 32'd3};
    run_stream(xs, -1, 0, 1'b0, 1'b0);

    // Impulse longer than the tap count: taps then zeros, pointer wraps.
    xs.delete();
    for (int i = 0; i < 15; i++) xs.push_back((i == 0) ? 32'd1 : 32'd0);
    run_stream(xs, -1, 0, 1'b1, 1'b0);

    // Output held back for 7 cycles.
    xs.delete();
    for (int i = 0; i < 3; i++) xs.push_back($urandom);
    run_stream(xs, -1, 2, 1'b0, 1'b0);

    // Zero-length run: INIT only, then done.
    pulse_start(32'd0);
    n = 0; b = 0; seen = 1'b0;
    while (!ap_done && b < 40) begin
      #1;
      if (data_WE == 4'hF) begin
        chk("init_addr", 32'(data_A), 32'(n * 4));
        chk("init_data", data_Di, 32'd0);
        n++;
      end
      if (ss_tready) seen = 1'b1;
      @(negedge clk);
      b++;
    end
    chk("init_cycles", 32'(n), 32'(NT));
    chk("len0_done", 32'(ap_done), 32'd1);
    chk("len0_no_ready", 32'(seen), 32'd0);
    ap_done_clr = 1'b1;
    @(negedge clk);
    ap_done_clr = 1'b0;

    // Early tlast on the second sample.
    xs = {32'd5, 32'd6, 32'd7, 32'd8};
    run_stream(xs, 1, 0, 1'b0, TLAST_CHK);
    xs = {32'd9, 32'd10};
    run_stream(xs, -1, 0, 1'b0, 1'b0);

    // Randomized taps, data and handshake timing.
    load_taps(1'b1);
    for (int r = 0; r < 4; r++) begin
      xs.delete();
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) xs.push_back($urandom);
      run_stream(xs, -1, 1, (r == 1), 1'b0);
    end

    // Reset in the middle of CALC (k = 5).
    pulse_start(32'd2);
    b = 0;
    while (!ss_tready && b < 30) begin
      @(negedge clk);
      b++;
    end
    chk("wait_ready", 32'(ss_tready), 32'd1);
    ss_tvalid = 1'b1;
    ss_tdata  = 32'd5;
    @(negedge clk);
    ss_tvalid = 1'b0;
    repeat (5) @(negedge clk);
    chk("calc_k5_mac_en", 32'(mac_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midcalc_rst_idle", 32'(ap_idle), 32'd1);
    chk("midcalc_rst_mac_en", 32'(mac_en), 32'd0);
    chk("midcalc_rst_data_WE", 32'(data_WE), 32'd0);
    chk("midcalc_rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    rst = 1'b0;
    xs = {32'd3, 32'd1};
    run_stream(xs, -1, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
